// File: rtl/uart_tx_sched.sv
// Two-port round-robin UART transmit scheduler.
// Each accepted byte goes out as an 8N1 frame timed by a per-frame baud counter.
module uart_tx_sched #(
  parameter int unsigned MAX_CNT = 10415
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic       gnt
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [15:0] TERM = 16'(MAX_CNT);

  state_t      state_q;
  logic        tx_q;
  logic        busy_q;
  logic        gnt_q;
  logic        last_q;
  logic [15:0] cnt_q;
  logic [7:0]  shift_q;
  logic [2:0]  idx_q;

  logic idle;
  logic tick;
  logic acc0;
  logic acc1;

  assign idle = (state_q == IDLE);
  assign tick = (cnt_q == TERM);

  // Port 0 wins unless port 1 is also waiting and port 0 went last.
  assign acc0 = idle && req0_valid && (!req1_valid || last_q);
  assign acc1 = idle && req1_valid && (!req0_valid || !last_q);

  assign req0_ready = acc0 && !rst;
  assign req1_ready = acc1 && !rst;

  assign tx   = tx_q;
  assign busy = busy_q;
  assign gnt  = gnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      if (state_q != IDLE) begin
        cnt_q <= tick ? '0 : cnt_q + 16'd1;
      end
      case (state_q)
        IDLE: begin
          if (acc0 || acc1) begin
            shift_q <= acc0 ? req0_data : req1_data;
            gnt_q   <= acc1;
            last_q  <= acc1;
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (tick) begin
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
              idx_q   <= idx_q + 3'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched with a frame-position reference model.
// Directed scenarios followed by a randomized phase.
module tb_uart_tx_sched;

  localparam int MC    = 3;
  localparam int BIT   = MC + 1;
  localparam int FRAME = 10 * BIT;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       v0 = 1'b0;
  logic       v1 = 1'b0;
  logic [7:0] d0 = 8'h00;
  logic [7:0] d1 = 8'h00;
  logic       r0;
  logic       r1;
  logic       tx;
  logic       busy;
  logic       gnt;

  int vectors = 0;
  int miscompares = 0;

  // reference model: where we are inside a 10-bit frame
  bit         m_active;
  int         m_pos;
  logic [9:0] m_bits;
  logic       m_gnt;
  logic       m_last;

  int refill0 = 0;
  int refill1 = 0;
  bit rnd = 1'b0;
  int busy_cnt = 0;

  uart_tx_sched #(.MAX_CNT(MC)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(v0),
    .req0_data (d0),
    .req0_ready(r0),
    .req1_valid(v1),
    .req1_data (d1),
    .req1_ready(r1),
    .tx        (tx),
    .busy      (busy),
    .gnt       (gnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_pos    = 0;
    m_bits   = '1;
    m_gnt    = 1'b0;
    m_last   = 1'b1;
  endtask

  task automatic step();
    logic e_tx;
    logic e_busy;
    logic e_r0;
    logic e_r1;
    @(negedge clk);
    if (m_active) begin
      e_tx   = m_bits[m_pos / BIT];
      e_busy = 1'b1;
      e_r0   = 1'b0;
      e_r1   = 1'b0;
    end else begin
      e_tx   = 1'b1;
      e_busy = 1'b0;
      e_r0   = !rst && v0 && (!v1 || m_last);
      e_r1   = !rst && v1 && (!v0 || !m_last);
    end
    chk("tx", tx, e_tx);
    chk("busy", busy, e_busy);
    chk("gnt", gnt, m_gnt);
    chk("req0_ready", r0, e_r0);
    chk("req1_ready", r1, e_r1);
    if (busy) busy_cnt++;
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else if (m_active) begin
      m_pos++;
      if (m_pos == FRAME) m_active = 1'b0;
    end else if (e_r0 || e_r1) begin
      m_active = 1'b1;
      m_pos    = 0;
      m_bits   = {1'b1, (e_r0 ? d0 : d1), 1'b0};
      m_gnt    = e_r1;
      m_last   = e_r1;
    end
    if (e_r0) begin
      if (refill0 == 0) v0 = 1'b0;
      else if (refill0 == 1) d0 = 8'($urandom);
    end
    if (e_r1) begin
      if (refill1 == 0) v1 = 1'b0;
      else if (refill1 == 1) d1 = 8'($urandom);
    end
    if (rnd) begin
      if (!v0 && $urandom_range(0, 3) == 0) begin
        v0 = 1'b1;
        d0 = 8'($urandom);
      end
      if (!v1 && $urandom_range(0, 3) == 0) begin
        v1 = 1'b1;
        d1 = 8'($urandom);
      end
    end
  endtask

  task automatic drain();
    refill0 = 0;
    refill1 = 0;
    for (int i = 0; i < 200; i++) begin
      if (!v0 && !v1 && !m_active) break;
      step();
    end
    chk("drained_busy", busy, 0);
  endtask

  initial begin
    model_reset();
    v0 = 1'b1;
    v1 = 1'b1;
    d0 = 8'h55;
    d1 = 8'h0F;
    #1 rst = 1'b1;
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_r0", r0, 0);
    chk("rst_r1", r1, 0);
    step();
    step();
    rst = 1'b0;

    // both held from reset release: 0,1,0 alternation
    refill0 = 2;
    refill1 = 2;
    repeat (3 * (FRAME + 1) + 2) step();
    drain();

    // single byte 0xA5 on port 0
    v0 = 1'b1;
    d0 = 8'hA5;
    busy_cnt = 0;
    repeat (FRAME + 10) step();
    chk("busy_len", busy_cnt, FRAME);

    // port 1 streaming, port 0 joins mid-frame
    v1 = 1'b1;
    d1 = 8'($urandom);
    refill1 = 1;
    repeat (2 * (FRAME + 1) + 17) step();
    v0 = 1'b1;
    d0 = 8'($urandom);
    repeat (3 * (FRAME + 1)) step();
    drain();

    // reset during data bit 3
    v0 = 1'b1;
    d0 = 8'($urandom);
    for (int i = 0; i < 40; i++) begin
      if (m_active && (m_pos / BIT) == 4) break;
      step();
    end
    chk("bit3_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_tx", tx, 1);
    chk("arst_busy", busy, 0);
    chk("arst_gnt", gnt, 0);
    step();
    rst = 1'b0;
    v1 = 1'b1;
    d1 = 8'($urandom);
    repeat (FRAME + 10) step();

    // randomized traffic
    rnd = 1'b1;
    repeat (600) step();
    rnd = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
